// File: rtl/bin2bcd_if.sv
// Handshake and result bundle between a binary-value producer and the
// bin2bcd_seq converter that feeds the two-digit display.
interface bin2bcd_if #(
  parameter int unsigned DATA_W = 7
);
  logic              start;
  logic [DATA_W-1:0] bin_in;
  logic              busy;
  logic              done;
  logic [3:0]        digit_tens;
  logic [3:0]        digit_ones;
  logic              ovf;

  modport master (
    output start, bin_in,
    input  busy, done, digit_tens, digit_ones, ovf
  );

  modport slave (
    input  start, bin_in,
    output busy, done, digit_tens, digit_ones, ovf
  );
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: one bit per clock, saturating to 99
// with an overflow flag, holding the last result for the display stage.
module bin2bcd_seq #(
  parameter int unsigned DATA_W = 7
) (
  input  logic      clk,
  input  logic      nRST,
  bin2bcd_if.slave  bus
);

  localparam int unsigned CNT_W  = $clog2(DATA_W + 1);
  localparam int unsigned SCR_W  = 12;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SHIFT  = 2'd1;
  localparam logic [1:0] UPDATE = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [DATA_W-1:0] bin_q,   bin_d;
  logic [SCR_W-1:0]  scr_q,   scr_d;
  logic [CNT_W-1:0]  cnt_q,   cnt_d;
  logic              busy_q,  busy_d;
  logic              done_q,  done_d;
  logic [3:0]        tens_q,  tens_d;
  logic [3:0]        ones_q,  ones_d;
  logic              ovf_q,   ovf_d;
  logic [SCR_W-1:0]  adj_c;

  function automatic logic [3:0] add3(input logic [3:0] n);
    return (n >= 4'd5) ? (n + 4'd3) : n;
  endfunction

  // State and datapath registers
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      bin_q   <= '0;
      scr_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      tens_q  <= 4'd0;
      ones_q  <= 4'd0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      scr_q   <= scr_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      tens_q  <= tens_d;
      ones_q  <= ones_d;
      ovf_q   <= ovf_d;
    end
  end

  // Next-state and datapath logic
  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    scr_d   = scr_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    tens_d  = tens_q;
    ones_d  = ones_q;
    ovf_d   = ovf_q;
    adj_c   = {add3(scr_q[11:8]), add3(scr_q[7:4]), add3(scr_q[3:0])};

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          bin_d   = bus.bin_in;
          scr_d   = '0;
          cnt_d   = CNT_W'(DATA_W);
          busy_d  = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        // Nibbles are corrected independently before the shift; no inter-nibble carry.
        {scr_d, bin_d} = {adj_c, bin_q} << 1;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_d == '0) begin
          state_d = UPDATE;
        end
      end
      UPDATE: begin
        if (scr_q[11:8] != 4'd0) begin
          tens_d = 4'd9;
          ones_d = 4'd9;
          ovf_d  = 1'b1;
        end else begin
          tens_d = scr_q[7:4];
          ones_d = scr_q[3:0];
          ovf_d  = 1'b0;
        end
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.digit_tens = tens_q;
  assign bus.digit_ones = ones_q;
  assign bus.ovf        = ovf_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: directed scenarios plus random values
// checked against a decimal-arithmetic reference.
module tb_bin2bcd_seq;

  localparam int unsigned DATA_W = 7;
  localparam int unsigned LAT    = DATA_W + 1;

  logic clk;
  logic nrst;
  int   checks;
  int   errors;

  bin2bcd_if #(.DATA_W(DATA_W)) bif ();

  bin2bcd_seq #(.DATA_W(DATA_W)) u_dut (
    .clk  (clk),
    .nRST (nrst),
    .bus  (bif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] ref_tens(input int v);
    return (v >= 100) ? 4'd9 : 4'((v / 10) % 10);
  endfunction

  function automatic logic [3:0] ref_ones(input int v);
    return (v >= 100) ? 4'd9 : 4'(v % 10);
  endfunction

  function automatic logic ref_ovf(input int v);
    return v >= 100;
  endfunction

  // Pulse start with value v, then count edges until done appears (bounded).
  task automatic do_conv(input int v, output int k);
    @(negedge clk);
    bif.start  = 1'b1;
    bif.bin_in = DATA_W'(v);
    @(negedge clk);
    bif.start  = 1'b0;
    k = 0;
    while (bif.done !== 1'b1 && k < 40) begin
      @(negedge clk);
      k++;
    end
  endtask

  task automatic apply_reset();
    bif.start  = 1'b0;
    bif.bin_in = '0;
    nrst = 1'b0;
    repeat (3) @(negedge clk);
    nrst = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if ({bif.busy, bif.done, bif.ovf, bif.digit_tens, bif.digit_ones} !== 11'd0) begin
      errors++;
      $display("FAIL reset_values busy=%b done=%b ovf=%b tens=%0d ones=%0d expected all 0",
               bif.busy, bif.done, bif.ovf, bif.digit_tens, bif.digit_ones);
    end
  endtask

  task automatic test_zero();
    int k;
    do_conv(0, k);
    checks++;
    if (k !== LAT) begin
      errors++;
      $display("FAIL zero_latency got %0d expected %0d", k, LAT);
    end
    checks++;
    if ({bif.digit_tens, bif.digit_ones, bif.ovf} !== 9'd0) begin
      errors++;
      $display("FAIL zero_result got %0d,%0d ovf=%b expected 0,0 ovf=0",
               bif.digit_tens, bif.digit_ones, bif.ovf);
    end
  endtask

  // Cycle-by-cycle view of one conversion of 57 after a 0,0 result.
  task automatic test_latency();
    @(negedge clk);
    bif.start  = 1'b1;
    bif.bin_in = DATA_W'(57);
    @(negedge clk);
    bif.start  = 1'b0;
    for (int k = 0; k <= int'(LAT); k++) begin
      logic exp_busy, exp_done;
      logic [3:0] exp_t, exp_o;
      exp_busy = (k < int'(LAT));
      exp_done = (k == int'(LAT));
      exp_t    = (k < int'(LAT)) ? 4'd0 : 4'd5;
      exp_o    = (k < int'(LAT)) ? 4'd0 : 4'd7;
      checks++;
      if (bif.busy !== exp_busy || bif.done !== exp_done ||
          bif.digit_tens !== exp_t || bif.digit_ones !== exp_o) begin
        errors++;
        $display("FAIL latency57 k=%0d busy=%b done=%b digits=%0d,%0d expected busy=%b done=%b digits=%0d,%0d",
                 k, bif.busy, bif.done, bif.digit_tens, bif.digit_ones,
                 exp_busy, exp_done, exp_t, exp_o);
      end
      if (k < int'(LAT)) @(negedge clk);
    end
    @(negedge clk);
    checks++;
    if (bif.done !== 1'b0) begin
      errors++;
      $display("FAIL done_width done=%b one cycle after pulse expected 0", bif.done);
    end
  endtask

  task automatic test_saturation();
    int vals[4] = '{99, 100, 127, 10};
    foreach (vals[i]) begin
      int k;
      do_conv(vals[i], k);
      checks++;
      if (k !== LAT || bif.digit_tens !== ref_tens(vals[i]) ||
          bif.digit_ones !== ref_ones(vals[i]) || bif.ovf !== ref_ovf(vals[i])) begin
        errors++;
        $display("FAIL saturation v=%0d lat=%0d got %0d,%0d ovf=%b expected lat=%0d %0d,%0d ovf=%b",
                 vals[i], k, bif.digit_tens, bif.digit_ones, bif.ovf,
                 LAT, ref_tens(vals[i]), ref_ones(vals[i]), ref_ovf(vals[i]));
      end
    end
  endtask

  task automatic test_ignore_start();
    int dones;
    dones = 0;
    @(negedge clk);
    bif.start  = 1'b1;
    bif.bin_in = DATA_W'(42);
    @(negedge clk);
    bif.start  = 1'b0;
    repeat (2) @(negedge clk);
    bif.start  = 1'b1;
    bif.bin_in = DATA_W'(88);
    @(negedge clk);
    bif.start  = 1'b0;
    for (int c = 0; c < 24; c++) begin
      if (bif.done === 1'b1) dones++;
      @(negedge clk);
    end
    checks++;
    if (dones !== 1) begin
      errors++;
      $display("FAIL ignore_start_pulses got %0d done pulses expected 1", dones);
    end
    checks++;
    if (bif.digit_tens !== 4'd4 || bif.digit_ones !== 4'd2 || bif.ovf !== 1'b0) begin
      errors++;
      $display("FAIL ignore_start_result got %0d,%0d ovf=%b expected 4,2 ovf=0",
               bif.digit_tens, bif.digit_ones, bif.ovf);
    end
  endtask

  task automatic test_back_to_back();
    int pulses[$];
    int wait_c;
    @(negedge clk);
    bif.start  = 1'b1;
    bif.bin_in = DATA_W'(23);
    @(negedge clk);
    for (int k = 0; k < 40; k++) begin
      if (bif.done === 1'b1) begin
        pulses.push_back(k);
        checks++;
        if (bif.digit_tens !== 4'd2 || bif.digit_ones !== 4'd3) begin
          errors++;
          $display("FAIL b2b_digits k=%0d got %0d,%0d expected 2,3",
                   k, bif.digit_tens, bif.digit_ones);
        end
      end
      @(negedge clk);
    end
    bif.start = 1'b0;
    checks++;
    if (pulses.size() != 4 || pulses[0] != int'(LAT)) begin
      errors++;
      $display("FAIL b2b_count got %0d pulses first=%0d expected 4 first=%0d",
               pulses.size(), (pulses.size() > 0) ? pulses[0] : -1, LAT);
    end
    for (int i = 1; i < pulses.size(); i++) begin
      checks++;
      if (pulses[i] - pulses[i-1] != int'(DATA_W) + 2) begin
        errors++;
        $display("FAIL b2b_period got %0d expected %0d",
                 pulses[i] - pulses[i-1], DATA_W + 2);
      end
    end
    wait_c = 0;
    while (bif.busy === 1'b1 && wait_c < 20) begin
      @(negedge clk);
      wait_c++;
    end
    checks++;
    if (bif.busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_drain busy=%b expected 0", bif.busy);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_midshift();
    int dones;
    int k;
    dones = 0;
    @(negedge clk);
    bif.start  = 1'b1;
    bif.bin_in = DATA_W'(76);
    @(negedge clk);
    bif.start  = 1'b0;
    repeat (4) @(negedge clk);
    nrst = 1'b0;
    #1;
    checks++;
    if ({bif.busy, bif.done, bif.ovf, bif.digit_tens, bif.digit_ones} !== 11'd0) begin
      errors++;
      $display("FAIL midshift_reset busy=%b done=%b ovf=%b digits=%0d,%0d expected all 0",
               bif.busy, bif.done, bif.ovf, bif.digit_tens, bif.digit_ones);
    end
    @(negedge clk);
    nrst = 1'b1;
    for (int c = 0; c < 12; c++) begin
      if (bif.done === 1'b1) dones++;
      @(negedge clk);
    end
    checks++;
    if (dones !== 0 || bif.busy !== 1'b0) begin
      errors++;
      $display("FAIL midshift_no_done got %0d pulses busy=%b expected 0 pulses busy=0",
               dones, bif.busy);
    end
    do_conv(76, k);
    checks++;
    if (k !== LAT || bif.digit_tens !== 4'd7 || bif.digit_ones !== 4'd6 || bif.ovf !== 1'b0) begin
      errors++;
      $display("FAIL midshift_restart lat=%0d got %0d,%0d ovf=%b expected lat=%0d 7,6 ovf=0",
               k, bif.digit_tens, bif.digit_ones, bif.ovf, LAT);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      int v;
      int k;
      v = int'($urandom_range(0, (1 << DATA_W) - 1));
      do_conv(v, k);
      checks++;
      if (k !== LAT || bif.digit_tens !== ref_tens(v) ||
          bif.digit_ones !== ref_ones(v) || bif.ovf !== ref_ovf(v)) begin
        errors++;
        $display("FAIL random v=%0d lat=%0d got %0d,%0d ovf=%b expected lat=%0d %0d,%0d ovf=%b",
                 v, k, bif.digit_tens, bif.digit_ones, bif.ovf,
                 LAT, ref_tens(v), ref_ones(v), ref_ovf(v));
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    nrst   = 1'b0;
    bif.start  = 1'b0;
    bif.bin_in = '0;
    test_reset();
    test_zero();
    test_latency();
    test_saturation();
    test_ignore_start();
    test_back_to_back();
    test_reset_midshift();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bin2bcd_seq.md
Name: bin2bcd_seq

Overview:
- Sequential binary-to-BCD converter that sits directly upstream of the two-digit seven-segment display stage.
- Converts a DATA_W-bit unsigned value into tens and ones BCD digits using iterative shift-and-add-3 (double dabble), one bit per clock.
- Holds the last valid result on registered outputs so the display sees stable digits A (tens) and B (ones) between conversions.
- Values of 100 and above saturate to 99 and assert an overflow flag.

Parameters:
- DATA_W, 7: width of the binary input; legal range 4..7 (maximum input 127).

Ports:
- clk  input  1  system clock, rising-edge active.
- nRST  input  1  asynchronous, active-low reset.
- start  input  1  request a conversion of bin_in; sampled only in IDLE.
- bin_in  input  DATA_W  unsigned binary value to convert.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse when digit_tens/digit_ones/ovf update.
- digit_tens  output  4  BCD tens digit, feeds display input A.
- digit_ones  output  4  BCD ones digit, feeds display input B.
- ovf  output  1  last converted value was >= 100; digits forced to 9,9.

Behaviour:
- Clock and reset: one clock, clk. Reset nRST is asynchronous and active-low.
- Reset values:
  - busy=0, done=0, ovf=0, digit_tens=0, digit_ones=0.
  - FSM in IDLE; internal shift register and bit counter cleared.
- FSM states: IDLE, SHIFT, UPDATE.
- IDLE:
  - On a clk edge with start=1: latch bin_in into the shift register, clear the 12-bit BCD scratch (hundreds/tens/ones nibbles), load bit counter with DATA_W, go to SHIFT.
  - busy goes 1 from that edge.
- SHIFT, each edge:
  - First, add 3 to every scratch nibble that is >=5.
  - Then shift {scratch, binary} left by 1.
  - Decrement the counter; when it reaches 0 after the shift, go to UPDATE.
  - Exactly DATA_W shift edges occur.
- UPDATE, one edge:
  - If hundreds nibble != 0: digit_tens=9, digit_ones=9, ovf=1.
  - Else: digit_tens and digit_ones take the scratch nibbles, ovf=0.
  - done=1 for exactly this one cycle; busy=0; return to IDLE.
- Latency: start sampled at edge N; outputs and done become valid after edge N+DATA_W+1 (8 cycles for DATA_W=7).
- Output stability:
  - digit_tens, digit_ones and ovf change only on the UPDATE edge.
  - They hold their previous value during SHIFT, so the display never shows intermediate scratch values.
- start while busy=1: ignored, not queued; bin_in changes during SHIFT have no effect.
- start held high continuously: a new conversion begins on the edge after done (IDLE re-entry), giving back-to-back throughput of one result per DATA_W+2 cycles.
- start on the same edge that UPDATE completes: FSM is not yet in IDLE, so the request is ignored.
- nRST low at any time, including mid-SHIFT: immediate return to reset values; the partial result is discarded and no done pulse is issued.
- Arithmetic: add-3 is applied per 4-bit nibble with no carry between nibbles. The scratch is 12 bits, so no information is lost for inputs up to 127.

Test Plan:
- Reset, then bin_in=0, start pulse -> done after 8 cycles; digit_tens=0, digit_ones=0, ovf=0.
- bin_in=57, 1-cycle start -> busy high for 7 shift cycles plus UPDATE; done at edge N+8; digit_tens=5, digit_ones=7; outputs stay 0 until that edge.
- bin_in=99 -> 9,9, ovf=0. Then bin_in=100 -> 9,9, ovf=1. Then bin_in=127 -> 9,9, ovf=1. Then bin_in=10 -> 1,0, ovf clears to 0.
- After converting 42, start at 3 cycles into busy with bin_in=88 -> ignored; result stays 4,2; exactly one done pulse.
- start held high with bin_in=23 -> done pulses repeat every 9 cycles (DATA_W+2); digits stay 2,3.
- Mid-conversion of 76, drive nRST low for 1 cycle at shift 4 -> busy=0, digits=0,0, ovf=0 immediately; no done; a fresh start with 76 gives 7,6.
